spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
Clocked SPI initiator (mode 0, single slave select) that drives sck/ss/mosi toward SPI peripherals such as the bit-reversal test slave on the perip bus.
A host issues one transfer of 1..MAX_BITS bits via a valid/ready request and gets the received bits back via a valid/ready response.
It sits between the NPC MMIO glue and the off-core SPI pins.

Parameters:
DIV, 1, sck half-period in clk cycles; must be >= 1; sck period = 2*DIV clk cycles.
MAX_BITS, 16, maximum transfer length in bits; LEN_W = $clog2(MAX_BITS)+1 (localparam).

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  synchronous active-low reset.
req_valid  input  1  host request valid.
req_ready  output  1  block can accept a request (high only in IDLE).
req_data  input  MAX_BITS  tx bits, right-aligned; bit len-1 is sent first.
req_len  input  LEN_W  number of bits to transfer.
rsp_valid  output  1  received data valid.
rsp_ready  input  1  host accepts response.
rsp_data  output  MAX_BITS  rx bits, right-aligned; first received bit at bit len-1; bits >= len are 0.
busy  output  1  high from request accept until response accepted.
sck  output  1  SPI clock, idle low.
ss  output  1  slave select, active low, idle high.
mosi  output  1  master out.
miso  input  1  master in.

Behaviour:
- Reset (rst_n=0 at posedge, including mid-transfer): state IDLE; sck=0, ss=1, mosi=0, rsp_valid=0, rsp_data=0, busy=0, req_ready=1. In-flight transfer is dropped; no response is produced.
- All SPI outputs are registered; no combinational path from miso to any output.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_data and len. Effective len = min(req_len, MAX_BITS).
  - If len = 0: go directly to DONE with rsp_data=0. ss and sck are never toggled.
  - Otherwise go to SETUP. On that same edge ss<=0, sck<=0, mosi<=req_data[len-1].
- SETUP: hold for DIV cycles, then sck<=1 and go to SHIFT_HI.
- SHIFT_HI: hold DIV cycles, then sck<=0. On that same falling edge:
  - sample miso into the rx shift register (shift in at LSB);
  - decrement the remaining-bit count;
  - if bits remain, drive mosi with the next tx bit and go to SHIFT_LO; else go to HOLD with mosi<=0.
- SHIFT_LO: hold DIV cycles, then sck<=1 and go to SHIFT_HI.
- HOLD: ss low, sck low for DIV cycles. Then ss<=1, rsp_valid<=1, rsp_data<=rx register, go to DONE.
- DONE: rsp_valid held high and rsp_data held stable until rsp_ready. On rsp_valid&&rsp_ready: rsp_valid<=0, go to IDLE; req_ready rises the next cycle.
- Timing: ss low for exactly (2*len+1)*DIV cycles. rsp_valid rises on the same edge ss rises. Exactly len rising and len falling sck edges per transfer.
- Bit ordering: the slave samples mosi on sck rise; mosi is stable for the full sck-high phase.
- req_valid while busy: ignored (req_ready=0). rsp_ready while rsp_valid=0: ignored.
- rsp_valid&&rsp_ready in the same cycle as a new req_valid: the new request is not accepted in that cycle.

Optional Feature:
SPI_MASTER_LSB_FIRST_EN:
- Defined: adds input port lsb_first (1 bit), sampled at request accept.
  - When 1, tx order is req_data[0] first, up to req_data[len-1].
  - rx bits fill from bit 0 upward, so the first received bit lands at bit 0 of rsp_data.
- Undefined: port absent; always MSB-first as specified above.

Test Plan:
- Loopback (miso tied to mosi), DIV=1, len=16, req_data=0x1234 -> rsp_data=0x1234; ss low exactly 33 cycles; 16 sck rising edges.
- With bitrev slave, DIV=2, len=16, req_data=0xA500 -> rsp_data=0xFFA5 (8 idle-high bits, then 0xA5); ss returns high with rsp_valid.
- len=0, req_data=0xFFFF -> rsp_valid one cycle after accept, rsp_data=0; ss and sck never toggle.
- len=20 (> MAX_BITS), loopback -> clamped to 16 bits; 16 sck pulses; rsp_data=req_data.
- Hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid and rsp_data stable; req_ready=0; second req_valid not accepted until response taken.
- Assert rst_n=0 after 5 sck pulses -> next cycle ss=1, sck=0, mosi=0, rsp_valid=0, req_ready=1. Subsequent loopback transfer of 0x00C3 with len=8 -> rsp_data=0x00C3.

Source files
------------

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator with one slave select; one transfer of up to MAX_BITS bits per request.
// Optional macro SPI_MASTER_LSB_FIRST_EN adds the lsb_first input to select LSB-first bit order.
module spi_master #(
  parameter int DIV = 1,
  parameter int MAX_BITS = 16,
  localparam int LEN_W = $clog2(MAX_BITS) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [MAX_BITS-1:0] req_data,
  input  logic [LEN_W-1:0]    req_len,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MAX_BITS-1:0] rsp_data,
  output logic                busy,
  output logic                sck,
  output logic                ss,
  output logic                mosi,
  input  logic                miso
`ifdef SPI_MASTER_LSB_FIRST_EN
  ,
  input  logic                lsb_first
`endif
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BITS);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] SHIFT_HI = 3'd2;
  localparam logic [2:0] SHIFT_LO = 3'd3;
  localparam logic [2:0] HOLD     = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  logic [2:0]          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W-1:0]    bits_r;
  logic [MAX_BITS-1:0] tx_r;
  logic [MAX_BITS-1:0] rx_r;
  logic [MAX_BITS-1:0] rsp_data_r;
  logic                sck_r;
  logic                ss_r;
  logic                mosi_r;
  logic                rsp_valid_r;
  logic                req_ready_r;
  logic                busy_r;

  logic [LEN_W-1:0]    eff_len_s;
  logic [LEN_W-1:0]    pad_s;
  logic [MAX_BITS-1:0] aligned_s;
  logic                load_first_s;
  logic [MAX_BITS-1:0] load_rest_s;
  logic                next_bit_s;
  logic [MAX_BITS-1:0] tx_shift_s;
  logic [MAX_BITS-1:0] rx_shift_s;
  logic [MAX_BITS-1:0] rx_final_s;
  logic                lsb_req_s;
  logic                lsb_sel_s;

`ifdef SPI_MASTER_LSB_FIRST_EN
  logic lsb_r;
  assign lsb_req_s = lsb_first;
  assign lsb_sel_s = lsb_r;

  // Bit order is frozen for the whole transfer at request accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lsb_r <= 1'b0;
    end else if (state_r == IDLE && req_valid) begin
      lsb_r <= lsb_first;
    end else begin
      lsb_r <= lsb_r;
    end
  end
`else
  assign lsb_req_s = 1'b0;
  assign lsb_sel_s = 1'b0;
`endif

  // Request clamping, tx bit sequencing and rx assembly for either bit order
  always_comb begin
    eff_len_s = (req_len > LEN_MAX) ? LEN_MAX : req_len;
    pad_s     = LEN_MAX - eff_len_s;
    aligned_s = req_data << pad_s;
    if (lsb_req_s) begin
      load_first_s = req_data[0];
      load_rest_s  = {1'b0, req_data[MAX_BITS-1:1]};
    end else begin
      load_first_s = aligned_s[MAX_BITS-1];
      load_rest_s  = {aligned_s[MAX_BITS-2:0], 1'b0};
    end
    // LSB-first rx enters at the top and is right-aligned once the length is known
    if (lsb_sel_s) begin
      next_bit_s = tx_r[0];
      tx_shift_s = {1'b0, tx_r[MAX_BITS-1:1]};
      rx_shift_s = {miso, rx_r[MAX_BITS-1:1]};
      rx_final_s = rx_r >> (LEN_MAX - len_r);
    end else begin
      next_bit_s = tx_r[MAX_BITS-1];
      tx_shift_s = {tx_r[MAX_BITS-2:0], 1'b0};
      rx_shift_s = {rx_r[MAX_BITS-2:0], miso};
      rx_final_s = rx_r;
    end
  end

  // Transfer FSM; every SPI pin and handshake output is a register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      bits_r      <= {LEN_W{1'b0}};
      tx_r        <= {MAX_BITS{1'b0}};
      rx_r        <= {MAX_BITS{1'b0}};
      rsp_data_r  <= {MAX_BITS{1'b0}};
      sck_r       <= 1'b0;
      ss_r        <= 1'b1;
      mosi_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            len_r       <= eff_len_s;
            bits_r      <= eff_len_s;
            rx_r        <= {MAX_BITS{1'b0}};
            cnt_r       <= CNT_MAX;
            if (eff_len_s == {LEN_W{1'b0}}) begin
              state_r     <= DONE;
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= {MAX_BITS{1'b0}};
            end else begin
              state_r <= SETUP;
              ss_r    <= 1'b0;
              sck_r   <= 1'b0;
              mosi_r  <= load_first_s;
              tx_r    <= load_rest_s;
            end
          end
        end
        SETUP, SHIFT_LO: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            sck_r   <= 1'b1;
            cnt_r   <= CNT_MAX;
            state_r <= SHIFT_HI;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        SHIFT_HI: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            sck_r  <= 1'b0;
            cnt_r  <= CNT_MAX;
            rx_r   <= rx_shift_s;
            bits_r <= bits_r - LEN_W'(1);
            if (bits_r > LEN_W'(1)) begin
              mosi_r  <= next_bit_s;
              tx_r    <= tx_shift_s;
              state_r <= SHIFT_LO;
            end else begin
              mosi_r  <= 1'b0;
              state_r <= HOLD;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            ss_r        <= 1'b1;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= rx_final_s;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          sck_r       <= 1'b0;
          ss_r        <= 1'b1;
          mosi_r      <= 1'b0;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign sck       = sck_r;
  assign ss        = ss_r;
  assign mosi      = mosi_r;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus pushes expected responses, a negedge monitor
// plays an SPI slave (or loopback), measures pin timing and checks each response.
module tb_spi_master;
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, busy, sck, ss, mosi, miso;
  logic [15:0] req_data, rsp_data;
  logic [4:0]  req_len;

  logic        loop_mode;
  logic [15:0] slv_pat, slv_tx, slv_rx;
  int          errors, checks;
  int          rises, ss_cnt;
  logic        prev_sck, prev_ss, prev_rsp_valid;
  logic [15:0] prev_rsp_data, mon_mask;

  typedef struct {
    logic [15:0] rsp;
    logic [15:0] tx;
    int          eff;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  assign miso = loop_mode ? mosi : slv_tx[15];

  spi_master #(.DIV(DIV), .MAX_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: SPI slave model, pin timing measurement and scoreboard comparison
  always @(negedge clk) begin
    if (!rst_n) begin
      ss_cnt = 0;
      rises  = 0;
      slv_rx = 16'h0;
    end else begin
      if (!ss) ss_cnt++;
      if (!ss && prev_ss) slv_tx = slv_pat;
      if (sck && !prev_sck) begin
        rises++;
        slv_rx = {slv_rx[14:0], mosi};
      end
      if (!sck && prev_sck) slv_tx = {slv_tx[14:0], 1'b0};
      if (rsp_valid && !prev_rsp_valid && sb_q.size() > 0 && sb_q[0].eff > 0)
        ck("ss_rise_with_rsp", 32'({prev_ss, ss}), 32'h1);
      if (rsp_valid && prev_rsp_valid) begin
        ck("rsp_data_hold", 32'(rsp_data), 32'(prev_rsp_data));
        ck("req_ready_while_rsp", 32'(req_ready), 32'h0);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got response %0h with empty scoreboard", rsp_data);
        end else begin
          mon_e = sb_q.pop_front();
          mon_mask = (mon_e.eff >= 16) ? 16'hFFFF : 16'((32'd1 << mon_e.eff) - 32'd1);
          ck("rsp_data", 32'(rsp_data), 32'(mon_e.rsp));
          ck("sck_rises", 32'(rises), 32'(mon_e.eff));
          ck("ss_low_cycles", 32'(ss_cnt), (mon_e.eff == 0) ? 32'h0 : 32'((2 * mon_e.eff + 1) * DIV));
          if (mon_e.eff > 0) ck("mosi_bits", 32'(slv_rx & mon_mask), 32'(mon_e.tx & mon_mask));
        end
        ss_cnt = 0;
        rises  = 0;
        slv_rx = 16'h0;
      end
    end
    prev_sck       = sck;
    prev_ss        = ss;
    prev_rsp_valid = rsp_valid;
    prev_rsp_data  = rsp_data;
  end

  // One transfer: called and returns just after a posedge
  task automatic send(input logic [15:0] d, input logic [4:0] l, input bit lp,
                      input logic [15:0] pat, input int stall);
    exp_t e;
    int   n;
    logic [15:0] m;
    e.eff = (l > 5'd16) ? 16 : int'(l);
    e.tx  = d;
    m = (e.eff >= 16) ? 16'hFFFF : 16'((32'd1 << e.eff) - 32'd1);
    if (lp)             e.rsp = d & m;
    else if (e.eff == 0) e.rsp = 16'h0;
    else                e.rsp = pat >> (16 - e.eff);
    n = 0;
    while (!req_ready && n < 1000) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: req_ready stayed 0, required 1");
      return;
    end
    loop_mode = lp;
    slv_pat   = pat;
    req_data  = d;
    req_len   = l;
    req_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    ck("busy_after_accept", 32'(busy), 32'h1);
    if (e.eff == 0) ck("len0_rsp_next_cycle", 32'(rsp_valid), 32'h1);
    n = 0;
    while (!rsp_valid && n < 2000) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: rsp_valid stayed 0, required 1");
      return;
    end
    for (int i = 0; i < stall; i++) begin
      if (stall >= 10) begin
        req_valid = 1'b1;
        req_data  = ~d;
        req_len   = 5'd16;
      end
      @(posedge clk); #1;
      if (stall >= 10) begin
        ck("stall_req_ready", 32'(req_ready), 32'h0);
        ck("stall_busy", 32'(busy), 32'h1);
        ck("stall_rsp_valid", 32'(rsp_valid), 32'h1);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    ck("req_ready_after_rsp", 32'(req_ready), 32'h1);
    if (stall >= 10) ck("no_accept_on_rsp_cycle", 32'(busy), 32'h0);
    req_valid = 1'b0;
  endtask

  initial begin
    int n;
    errors = 0; checks = 0;
    rises = 0; ss_cnt = 0;
    prev_sck = 1'b0; prev_ss = 1'b1; prev_rsp_valid = 1'b0; prev_rsp_data = 16'h0;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_data = 16'h0; req_len = 5'd0;
    loop_mode = 1'b1; slv_pat = 16'h0; slv_tx = 16'h0; slv_rx = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    ck("reset_ss", 32'(ss), 32'h1);
    ck("reset_sck", 32'(sck), 32'h0);
    ck("reset_mosi", 32'(mosi), 32'h0);
    ck("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    ck("reset_rsp_data", 32'(rsp_data), 32'h0);
    ck("reset_req_ready", 32'(req_ready), 32'h1);
    ck("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(16'h1234, 5'd16, 1'b1, 16'h0000, 0);
    send(16'hA500, 5'd16, 1'b0, 16'hFFA5, 0);
    send(16'hFFFF, 5'd0,  1'b1, 16'h0000, 1);
    send(16'hC3A5, 5'd20, 1'b1, 16'h0000, 0);
    send(16'h5A5A, 5'd16, 1'b0, 16'h1357, 10);
    send(16'h0001, 5'd1,  1'b1, 16'h0000, 0);
    send(16'h0000, 5'd3,  1'b0, 16'hA000, 2);

    // Reset in the middle of a transfer
    loop_mode = 1'b1;
    req_data  = 16'hBEEF;
    req_len   = 5'd16;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rises < 5 && n < 500) begin @(posedge clk); #1; n++; end
    ck("pulses_before_reset", 32'(rises), 32'h5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    ck("midreset_ss", 32'(ss), 32'h1);
    ck("midreset_sck", 32'(sck), 32'h0);
    ck("midreset_mosi", 32'(mosi), 32'h0);
    ck("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
    ck("midreset_req_ready", 32'(req_ready), 32'h1);
    ck("midreset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h00C3, 5'd8, 1'b1, 16'h0000, 0);

    for (int i = 0; i < 24; i++)
      send(16'($urandom), 5'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
           16'($urandom), $urandom_range(0, 3));

    repeat (5) @(posedge clk);
    #1;
    ck("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
